// File: rtl/zap_wb_port_sequencer.sv
// Serialises memory-stage results onto the single register-file write port.
// Loads with base writeback take two beats: updated base first, load data second.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new result; one write (or none) per accepted result
// SECOND | replaying the buffered load data; upstream held off (o_ready=0)
module zap_wb_port_sequencer #(
    parameter int          PHY_REGS       = 46,
    parameter int          RAZ_INDEX      = 45,
    parameter logic [15:0] DUAL_COUNT_MAX = 16'hFFFF,
    localparam int         IW             = $clog2(PHY_REGS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear_from_writeback,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_mem_load,
    input  logic [1:0]    i_mem_fault,
    input  logic [31:0]   i_alu_result,
    input  logic [IW-1:0] i_destination_index,
    input  logic [31:0]   i_mem_rd_data,
    input  logic [IW-1:0] i_mem_srcdest_index,
    output logic          o_wr_en,
    output logic [IW-1:0] o_wr_index,
    output logic [31:0]   o_wr_data,
    output logic          o_abort,
    output logic [15:0]   o_dual_count
);

    localparam logic [IW-1:0] RAZ_IDX = RAZ_INDEX[IW-1:0];

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] hold_index, hold_index_nxt;
    logic [31:0]   hold_data, hold_data_nxt;
    logic          wr_en_nxt;
    logic [IW-1:0] wr_index_nxt;
    logic [31:0]   wr_data_nxt;
    logic          abort_nxt;
    logic [15:0]   dual_count_nxt;

    logic accept;
    logic dst_live;
    logic src_live;
    logic faulted;

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid & o_ready & ~i_clear_from_writeback;
    assign dst_live = (i_destination_index != RAZ_IDX);
    assign src_live = (i_mem_srcdest_index != RAZ_IDX);
    assign faulted  = |i_mem_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            o_wr_en      <= 1'b0;
            o_wr_index   <= RAZ_IDX;
            o_wr_data    <= 32'd0;
            o_abort      <= 1'b0;
            o_dual_count <= 16'd0;
            hold_index   <= '0;
            hold_data    <= 32'd0;
        end else begin
            state        <= state_nxt;
            o_wr_en      <= wr_en_nxt;
            o_wr_index   <= wr_index_nxt;
            o_wr_data    <= wr_data_nxt;
            o_abort      <= abort_nxt;
            o_dual_count <= dual_count_nxt;
            hold_index   <= hold_index_nxt;
            hold_data    <= hold_data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wr_en_nxt      = 1'b0;
        wr_index_nxt   = o_wr_index;
        wr_data_nxt    = o_wr_data;
        abort_nxt      = 1'b0;
        dual_count_nxt = o_dual_count;
        hold_index_nxt = hold_index;
        hold_data_nxt  = hold_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (i_mem_load && faulted) begin
                        abort_nxt = 1'b1;
                    end else if (i_mem_load && src_live && dst_live) begin
                        // Base goes out now so a same-register load ends with the load data.
                        wr_en_nxt      = 1'b1;
                        wr_index_nxt   = i_destination_index;
                        wr_data_nxt    = i_alu_result;
                        hold_index_nxt = i_mem_srcdest_index;
                        hold_data_nxt  = i_mem_rd_data;
                        state_nxt      = SECOND;
                        if (o_dual_count != DUAL_COUNT_MAX)
                            dual_count_nxt = o_dual_count + 16'd1;
                    end else if (i_mem_load && src_live) begin
                        wr_en_nxt    = 1'b1;
                        wr_index_nxt = i_mem_srcdest_index;
                        wr_data_nxt  = i_mem_rd_data;
                    end else if (dst_live) begin
                        wr_en_nxt    = 1'b1;
                        wr_index_nxt = i_destination_index;
                        wr_data_nxt  = i_alu_result;
                    end
                end
            end
            SECOND: begin
                // Flush cannot cancel this beat: the instruction's first beat already committed.
                wr_en_nxt    = 1'b1;
                wr_index_nxt = hold_index;
                wr_data_nxt  = hold_data;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_zap_wb_port_sequencer.sv
// Directed bench for zap_wb_port_sequencer: expected write-port beats are queued
// as each step is driven and popped when the registered outputs appear.
module tb_zap_wb_port_sequencer;

    localparam int          IW  = 6;
    localparam logic [5:0]  RAZ = 6'd45;
    localparam logic [15:0] SAT = 16'd4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_clear_from_writeback;
    logic          i_valid;
    logic          o_ready;
    logic          i_mem_load;
    logic [1:0]    i_mem_fault;
    logic [31:0]   i_alu_result;
    logic [IW-1:0] i_destination_index;
    logic [31:0]   i_mem_rd_data;
    logic [IW-1:0] i_mem_srcdest_index;
    logic          o_wr_en;
    logic [IW-1:0] o_wr_index;
    logic [31:0]   o_wr_data;
    logic          o_abort;
    logic [15:0]   o_dual_count;

    zap_wb_port_sequencer #(
        .PHY_REGS      (46),
        .RAZ_INDEX     (45),
        .DUAL_COUNT_MAX(SAT)
    ) dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_clear_from_writeback(i_clear_from_writeback),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .i_mem_load            (i_mem_load),
        .i_mem_fault           (i_mem_fault),
        .i_alu_result          (i_alu_result),
        .i_destination_index   (i_destination_index),
        .i_mem_rd_data         (i_mem_rd_data),
        .i_mem_srcdest_index   (i_mem_srcdest_index),
        .o_wr_en               (o_wr_en),
        .o_wr_index            (o_wr_index),
        .o_wr_data             (o_wr_data),
        .o_abort               (o_abort),
        .o_dual_count          (o_dual_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        en;
        logic [5:0]  idx;
        logic [31:0] data;
        logic        abort;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the beat it should produce, then check it.
    task automatic step(input string tag, input logic v, input logic ld, input logic [1:0] flt,
                        input logic [31:0] alu, input logic [5:0] dst, input logic [31:0] rd,
                        input logic [5:0] src, input logic clr, input logic exp_ready, input exp_t e);
        exp_t got;
        i_valid                = v;
        i_mem_load             = ld;
        i_mem_fault            = flt;
        i_alu_result           = alu;
        i_destination_index    = dst;
        i_mem_rd_data          = rd;
        i_mem_srcdest_index    = src;
        i_clear_from_writeback = clr;
        #1;
        chk({tag, ".ready"}, {31'd0, o_ready}, {31'd0, exp_ready});
        q.push_back(e);
        @(posedge i_clk);
        #1;
        total++;
        assert (q.size() != 0) else begin
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (q.size() != 0) begin
            got = q.pop_front();
            chk({tag, ".wr_en"}, {31'd0, o_wr_en}, {31'd0, got.en});
            chk({tag, ".abort"}, {31'd0, o_abort}, {31'd0, got.abort});
            chk({tag, ".count"}, {16'd0, o_dual_count}, {16'd0, got.cnt});
            if (got.en) begin
                chk({tag, ".idx"}, {26'd0, o_wr_index}, {26'd0, got.idx});
                chk({tag, ".data"}, o_wr_data, got.data);
            end
        end
    endtask

    function automatic exp_t w(input logic [5:0] idx, input logic [31:0] data, input logic [15:0] cnt);
        return '{en: 1'b1, idx: idx, data: data, abort: 1'b0, cnt: cnt};
    endfunction

    function automatic exp_t nw(input logic ab, input logic [15:0] cnt);
        return '{en: 1'b0, idx: 6'd0, data: 32'd0, abort: ab, cnt: cnt};
    endfunction

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0; i_mem_load = 1'b0; i_mem_fault = 2'b00; i_clear_from_writeback = 1'b0;
        i_alu_result = '0; i_destination_index = RAZ; i_mem_rd_data = '0; i_mem_srcdest_index = RAZ;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("rst.abort", {31'd0, o_abort}, 32'd0);
        chk("rst.count", {16'd0, o_dual_count}, 32'd0);
        chk("rst.idx", {26'd0, o_wr_index}, {26'd0, RAZ});
        chk("rst.data", o_wr_data, 32'd0);
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        i_reset = 1'b0;

        step("nonload", 1, 0, 2'b00, 32'h1234, 6'd3, 32'h0, RAZ, 0, 1, w(6'd3, 32'h1234, 16'd0));
        step("idle0", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 1, nw(0, 16'd0));

        step("ldr.b1", 1, 1, 2'b00, 32'h1004, 6'd5, 32'hDEADBEEF, 6'd7, 0, 1, w(6'd5, 32'h1004, 16'd1));
        step("ldr.b2", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 0, w(6'd7, 32'hDEADBEEF, 16'd1));

        step("same.b1", 1, 1, 2'b00, 32'h10, 6'd4, 32'h20, 6'd4, 0, 1, w(6'd4, 32'h10, 16'd2));
        step("same.b2", 1, 0, 2'b00, 32'h99, 6'd9, 32'h0, RAZ, 0, 0, w(6'd4, 32'h20, 16'd2));
        step("b2b", 1, 0, 2'b00, 32'h99, 6'd9, 32'h0, RAZ, 0, 1, w(6'd9, 32'h99, 16'd2));

        step("abort", 1, 1, 2'b01, 32'h1004, 6'd5, 32'hBAD, 6'd7, 0, 1, nw(1, 16'd2));
        step("abort.after", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 1, nw(0, 16'd2));

        step("single", 1, 1, 2'b00, 32'h77, RAZ, 32'h55, 6'd8, 0, 1, w(6'd8, 32'h55, 16'd2));
        step("ld_srcraz", 1, 1, 2'b00, 32'h66, 6'd6, 32'h44, RAZ, 0, 1, w(6'd6, 32'h66, 16'd2));
        step("ld_bothraz", 1, 1, 2'b00, 32'h66, RAZ, 32'h44, RAZ, 0, 1, nw(0, 16'd2));
        step("nl_raz", 1, 0, 2'b00, 32'h66, RAZ, 32'h0, RAZ, 0, 1, nw(0, 16'd2));

        step("clr2.b1", 1, 1, 2'b00, 32'hA, 6'd10, 32'hB, 6'd11, 0, 1, w(6'd10, 32'hA, 16'd3));
        step("clr2.b2", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 1, 0, w(6'd11, 32'hB, 16'd3));
        step("clr_idle", 1, 0, 2'b00, 32'hC, 6'd12, 32'h0, RAZ, 1, 1, nw(0, 16'd3));
        step("clr_after", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 1, nw(0, 16'd3));

        step("sat1.b1", 1, 1, 2'b00, 32'h1, 6'd1, 32'h2, 6'd2, 0, 1, w(6'd1, 32'h1, 16'd4));
        step("sat1.b2", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 0, w(6'd2, 32'h2, 16'd4));
        step("sat2.b1", 1, 1, 2'b00, 32'h3, 6'd1, 32'h4, 6'd2, 0, 1, w(6'd1, 32'h3, SAT));
        step("sat2.b2", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 0, w(6'd2, 32'h4, SAT));

        step("rst2.b1", 1, 1, 2'b00, 32'hE, 6'd13, 32'hF, 6'd14, 0, 1, w(6'd13, 32'hE, SAT));
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("rst2.ready_before", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        chk("rst2.wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("rst2.ready", {31'd0, o_ready}, 32'd1);
        chk("rst2.count", {16'd0, o_dual_count}, 32'd0);
        chk("rst2.idx", {26'd0, o_wr_index}, {26'd0, RAZ});
        i_reset = 1'b0;
        step("rst2.after", 0, 0, 2'b00, 32'h0, RAZ, 32'h0, RAZ, 0, 1, nw(0, 16'd0));
        step("rst2.next", 1, 0, 2'b00, 32'h42, 6'd2, 32'h0, RAZ, 0, 1, w(6'd2, 32'h42, 16'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
